// File: rtl/qvalue_compute_seq.sv
// Q-value engine: normalised energy and reciprocal hop terms from one shared restoring divider, then an alpha-weighted mix.
// Latency: done pulses 2N+2 clock edges after start is sampled (N = WORD_WIDTH+FRAC_BITS), independent of operands.
// Backpressure: none; start is only honoured in IDLE and ignored while busy, so inputs may change freely while busy.
module qvalue_compute_seq #(
    parameter int WORD_WIDTH = 16,
    parameter int FRAC_BITS  = 11   // must be smaller than WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] minEnergy,
    input  logic [WORD_WIDTH-1:0] maxEnergy,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] alpha,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] q_energy,
    output logic [WORD_WIDTH-1:0] q_hop,
    output logic [WORD_WIDTH-1:0] q_value
);

    localparam int N  = WORD_WIDTH + FRAC_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [WORD_WIDTH-1:0] ONE        = {{(WORD_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;
    localparam logic [CW-1:0]         CNT_E_LAST = CW'(N);
    localparam logic [CW-1:0]         CNT_H_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, DIV_E, DIV_H, COMBINE} state_t;

    state_t state, state_nx;

    // Operands frozen at capture; nothing upstream can disturb a running computation.
    logic [WORD_WIDTH-1:0] my_r, min_r, max_r, hop_r, alpha_r;
    logic [CW-1:0]         cnt;
    logic [WORD_WIDTH-1:0] rem;
    logic [N-1:0]          quo;     // numerator shifts out the top, quotient bits shift in at the bottom
    logic [WORD_WIDTH-1:0] div_r;
    logic [WORD_WIDTH-1:0] qe_div;

    logic [WORD_WIDTH:0]     trial;
    logic                    take;
    logic [WORD_WIDTH-1:0]   rem_nx;
    logic [N-1:0]            quo_nx;
    logic [WORD_WIDTH-1:0]   qe_fin, qh_fin, alpha_c, qv_fin;
    logic [2*WORD_WIDTH-1:0] mix, mix_sh;

    assign busy = (state != IDLE);

    // One restoring-division step on the shared divider registers.
    always_comb begin
        trial  = {rem, quo[N-1]};
        take   = (trial >= {1'b0, div_r});
        rem_nx = take ? WORD_WIDTH'(trial - {1'b0, div_r}) : trial[WORD_WIDTH-1:0];
        quo_nx = {quo[N-2:0], take};
    end

    // Apply the degenerate-case overrides and form the weighted mix.
    always_comb begin
        if (max_r <= min_r)      qe_fin = ONE;
        else if (my_r <= min_r)  qe_fin = '0;
        else if (my_r >= max_r)  qe_fin = ONE;
        else                     qe_fin = qe_div;

        // Any quotient above ONE can only come from a small or zero divisor, which the override already covers.
        if (hop_r < ONE || |(quo >> WORD_WIDTH)) qh_fin = ONE;
        else                                      qh_fin = quo[WORD_WIDTH-1:0];

        alpha_c = (alpha_r > ONE) ? ONE : alpha_r;
        mix     = {{WORD_WIDTH{1'b0}}, alpha_c} * {{WORD_WIDTH{1'b0}}, qe_fin}
                + {{WORD_WIDTH{1'b0}}, ONE - alpha_c} * {{WORD_WIDTH{1'b0}}, qh_fin};
        mix_sh  = mix >> FRAC_BITS;
        qv_fin  = (|(mix_sh >> WORD_WIDTH)) ? ONE : mix_sh[WORD_WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: each divide phase ends on its iteration count, COMBINE lasts one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = DIV_E;
            DIV_E:   if (cnt == CNT_E_LAST) state_nx = DIV_H;
            DIV_H:   if (cnt == CNT_H_LAST) state_nx = COMBINE;
            COMBINE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture, divider load/iterate (first DIV_E cycle loads), result load with done pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            my_r <= '0; min_r <= '0; max_r <= '0; hop_r <= '0; alpha_r <= '0;
            cnt <= '0; rem <= '0; quo <= '0; div_r <= '0; qe_div <= '0;
            q_energy <= '0; q_hop <= '0; q_value <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        my_r    <= myEnergy;
                        min_r   <= minEnergy;
                        max_r   <= maxEnergy;
                        hop_r   <= hopsFromSink;
                        alpha_r <= alpha;
                    end
                end
                DIV_E: begin
                    if (cnt == '0) begin
                        rem   <= '0;
                        quo   <= {WORD_WIDTH'(my_r - min_r), {FRAC_BITS{1'b0}}};
                        div_r <= max_r - min_r;
                        cnt   <= cnt + 1'b1;
                    end else if (cnt == CNT_E_LAST) begin
                        // Last energy step: keep its quotient and reload the divider for the hop term.
                        qe_div <= (|(quo_nx >> WORD_WIDTH)) ? ONE : quo_nx[WORD_WIDTH-1:0];
                        rem    <= '0;
                        quo    <= {ONE, {FRAC_BITS{1'b0}}};
                        div_r  <= hop_r;
                        cnt    <= '0;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_H: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                end
                COMBINE: begin
                    q_energy <= qe_fin;
                    q_hop    <= qh_fin;
                    q_value  <= qv_fin;
                    done     <= 1'b1;
                    cnt      <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_qvalue_compute_seq.sv
module tb_qvalue_compute_seq;

    localparam int  W     = 16;
    localparam int  F     = 11;
    localparam int  LAT   = 2 * (W + F) + 2;
    localparam longint ONE_L = 64'd1 << F;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] myEnergy = '0, minEnergy = '0, maxEnergy = '0, hopsFromSink = '0, alpha = '0;
    logic         busy, done;
    logic [W-1:0] q_energy, q_hop, q_value;

    int checks = 0;
    int errors = 0;

    qvalue_compute_seq #(.WORD_WIDTH(W), .FRAC_BITS(F)) dut (
        .clk(clk), .nrst(nrst), .start(start),
        .myEnergy(myEnergy), .minEnergy(minEnergy), .maxEnergy(maxEnergy),
        .hopsFromSink(hopsFromSink), .alpha(alpha),
        .busy(busy), .done(done),
        .q_energy(q_energy), .q_hop(q_hop), .q_value(q_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic straight from the rules.
    function automatic longint ref_qe(input longint me, input longint mn, input longint mx);
        if (mx <= mn) return ONE_L;
        if (me <= mn) return 0;
        if (me >= mx) return ONE_L;
        return ((me - mn) * ONE_L) / (mx - mn);
    endfunction

    function automatic longint ref_qh(input longint hp);
        if (hp < ONE_L) return ONE_L;
        return (ONE_L * ONE_L) / hp;
    endfunction

    function automatic longint ref_qv(input longint al, input longint qe, input longint qh);
        longint a;
        a = (al > ONE_L) ? ONE_L : al;
        return (a * qe + (ONE_L - a) * qh) / ONE_L;
    endfunction

    // One transaction; noise=1 scribbles the inputs and fires extra starts while busy.
    task automatic run_op(input string tag, input logic [W-1:0] me, input logic [W-1:0] mn,
                          input logic [W-1:0] mx, input logic [W-1:0] hp, input logic [W-1:0] al,
                          input bit noise);
        longint eqe, eqh, eqv;
        int first, ndone;
        logic [W-1:0] oe, oh, ov;
        eqe = ref_qe(me, mn, mx);
        eqh = ref_qh(hp);
        eqv = ref_qv(al, eqe, eqh);
        first = 0; ndone = 0; oe = '0; oh = '0; ov = '0;
        @(negedge clk);
        myEnergy = me; minEnergy = mn; maxEnergy = mx; hopsFromSink = hp; alpha = al;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            if (noise && (k == 1 || k == 5 || k == 30)) begin
                myEnergy = W'($urandom); minEnergy = W'($urandom); maxEnergy = W'($urandom);
                hopsFromSink = W'($urandom); alpha = W'($urandom);
                start = (k != 1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) first = k;
            end
            if (k == 1)       check({tag, " busy_start"}, 32'(busy), 32'd1);
            if (k == LAT - 1) check({tag, " busy_end"}, 32'(busy), 32'd1);
            if (k == LAT) begin
                check({tag, " busy_done"}, 32'(busy), 32'd0);
                oe = q_energy; oh = q_hop; ov = q_value;
            end
        end
        check({tag, " latency"}, 32'(first), 32'(LAT));
        check({tag, " done_count"}, 32'(ndone), 32'd1);
        check({tag, " q_energy"}, 32'(oe), 32'(eqe));
        check({tag, " q_hop"}, 32'(oh), 32'(eqh));
        check({tag, " q_value"}, 32'(ov), 32'(eqv));
        check({tag, " q_value_hold"}, 32'(q_value), 32'(eqv));
    endtask

    initial begin
        int ndone;
        logic [W-1:0] mn, mx, me, hp, al;

        // Power-up reset values.
        #3;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst q_energy", 32'(q_energy), 32'd0);
        check("rst q_hop", 32'(q_hop), 32'd0);
        check("rst q_value", 32'(q_value), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors.
        run_op("v_full",     16'h8000, 16'h4000, 16'h8000, 16'h0800, 16'h0400, 1'b0);
        run_op("v_half_a4",  16'h6000, 16'h4000, 16'h8000, 16'h1000, 16'h0400, 1'b0);
        run_op("v_half_a8",  16'h6000, 16'h4000, 16'h8000, 16'h1000, 16'h0800, 1'b0);
        run_op("v_half_aff", 16'h6000, 16'h4000, 16'h8000, 16'h1000, 16'hFFFF, 1'b0);
        run_op("v_zero",     16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        run_op("v_below",    16'h1000, 16'h4000, 16'h8000, 16'h3000, 16'h0800, 1'b0);
        run_op("v_above",    16'hF000, 16'h4000, 16'h8000, 16'h07FF, 16'h0200, 1'b0);
        run_op("v_mix",      16'h5555, 16'h1234, 16'hFEDC, 16'hFFFF, 16'h0333, 1'b0);
        run_op("v_busy_noise", 16'h6000, 16'h4000, 16'h8000, 16'h1000, 16'h0400, 1'b1);

        // Reset in the middle of a computation.
        @(negedge clk);
        myEnergy = 16'h6000; minEnergy = 16'h4000; maxEnergy = 16'h8000;
        hopsFromSink = 16'h1000; alpha = 16'h0400;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("mid_rst busy", 32'(busy), 32'd0);
        check("mid_rst done", 32'(done), 32'd0);
        check("mid_rst q_energy", 32'(q_energy), 32'd0);
        check("mid_rst q_hop", 32'(q_hop), 32'd0);
        check("mid_rst q_value", 32'(q_value), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        ndone = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("mid_rst no_done", 32'(ndone), 32'd0);
        run_op("after_rst", 16'h7000, 16'h2000, 16'hA000, 16'h1800, 16'h0600, 1'b0);

        // Randomised operands against the model.
        for (int i = 0; i < 24; i++) begin
            mn = W'($urandom);
            mx = W'($urandom);
            me = W'($urandom);
            if (i % 3 == 0 && mx > mn) me = W'($urandom_range(int'(mx), int'(mn)));
            hp = (i % 4 == 0) ? W'($urandom_range(0, 16'h0900)) : W'($urandom);
            al = W'($urandom_range(0, 16'h1000));
            run_op("rand", me, mn, mx, hp, al, (i % 5 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qvalue_compute_seq.md
QVALUE_COMPUTE_SEQ -- requirements
Module: qvalue_compute_seq

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: width of all data ports.
REQ-002 SHALL have parameter FRAC_BITS, default 11: fixed-point fraction bits, so 1.0 = ONE = 2^FRAC_BITS (0x0800 at default); SHALL satisfy FRAC_BITS < WORD_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 myEnergy  input  WORD_WIDTH  own residual energy, unsigned raw units.
REQ-007 minEnergy  input  WORD_WIDTH  neighbourhood minimum energy, unsigned.
REQ-008 maxEnergy  input  WORD_WIDTH  neighbourhood maximum energy, unsigned.
REQ-009 hopsFromSink  input  WORD_WIDTH  hop count, fixed-point (2048 = 1 hop at default).
REQ-010 alpha  input  WORD_WIDTH  energy weight, fixed-point, 0..ONE.
REQ-011 busy  output  1  high in every non-IDLE state.
REQ-012 done  output  1  one-cycle pulse when results update.
REQ-013 q_energy  output  WORD_WIDTH  normalised energy term.
REQ-014 q_hop  output  WORD_WIDTH  reciprocal hop term.
REQ-015 q_value  output  WORD_WIDTH  weighted Q-value.

Function
REQ-016 SHALL use FSM states IDLE, DIV_E, DIV_H, COMBINE; N = WORD_WIDTH+FRAC_BITS (27 at default).
REQ-017 IDLE: start=1 SHALL capture all five data inputs into registers and go to DIV_E; start=0 stays IDLE.
REQ-018 start while busy SHALL be ignored; captured operands SHALL not change until next IDLE capture.
REQ-019 DIV_E SHALL run a one-bit-per-cycle restoring divider for exactly N cycles on numerator (myEnergy-minEnergy)<<FRAC_BITS, divisor (maxEnergy-minEnergy), then go to DIV_H.
REQ-020 DIV_H SHALL reuse the same divider for exactly N cycles on numerator ONE<<FRAC_BITS, divisor hopsFromSink, then go to COMBINE.
REQ-021 Latency SHALL be fixed: done high exactly 2N+2 rising edges after the edge sampling start (56 at default), independent of operand values.
REQ-022 Energy overrides (applied over the divider result): maxEnergy<=minEnergy -> ONE; else myEnergy<=minEnergy -> 0; else myEnergy>=maxEnergy -> ONE.
REQ-023 Hop override: hopsFromSink<ONE (including 0) -> q_hop = ONE; no divide-by-zero artefact SHALL reach any output.
REQ-024 alpha>ONE SHALL be clamped to ONE before use.
REQ-025 COMBINE SHALL compute q_value = (alpha*q_energy + (ONE-alpha)*q_hop) >> FRAC_BITS with 2*WORD_WIDTH-bit intermediates, truncating; result never exceeds ONE.
REQ-026 COMBINE SHALL load q_energy, q_hop, q_value simultaneously, pulse done for one cycle, return to IDLE.
REQ-027 Outputs SHALL hold their last values between done pulses; start may be sampled in the cycle done is high (IDLE reached) only from the following edge.

Reset
REQ-028 nrst low SHALL immediately force IDLE, busy=0, done=0, q_energy=q_hop=q_value=0, clear divider state, regardless of clock.
REQ-029 Reset mid-computation SHALL abort with no done pulse; first start after release behaves as from power-up.

Verification
REQ-030 myE=0x8000, min=0x4000, max=0x8000, hops=0x0800, alpha=0x0400 -> after 56 cycles q_energy=0x0800, q_hop=0x0800, q_value=0x0800, done 1 cycle.
REQ-031 myE=0x6000, min=0x4000, max=0x8000, hops=0x1000, alpha=0x0400 -> q_energy=0x0400, q_hop=0x0400, q_value=0x0400; alpha=0x0800 -> q_value=0x0400; alpha=0xFFFF -> clamped, q_value=0x0400.
REQ-032 min=max=0, hops=0, alpha=0 -> q_energy=0x0800, q_hop=0x0800, q_value=0x0800, latency still 56.
REQ-033 Start pulses at cycles 5 and 30 after a valid start at 0 -> single done at cycle 56, results from cycle-0 operands; input changes during busy ignored.
REQ-034 nrst asserted at cycle 20 of a computation -> outputs 0, busy=0 asynchronously, no done; new start after release -> correct result 56 cycles later.
